// File: rtl/vdp18_vram_pkg.sv
// Shared types and widths for the VDP18 VRAM access scheduler.
package vdp18_vram_pkg;

  localparam int unsigned VRAM_AW = 14;
  localparam int unsigned VRAM_DW = 8;

  // Bit positions in the request vector handed to the priority select.
  localparam int unsigned REQ_CPU = 0;
  localparam int unsigned REQ_SPR = 1;
  localparam int unsigned REQ_VID = 2;
  localparam int unsigned REQ_REF = 3;

  typedef enum logic [2:0] {NONE, REF, VID, SPR, CPU} owner_t;

  typedef enum logic {IDLE, ACCESS} state_t;

endpackage

// File: rtl/vdp18_vram_prio.sv
// Combinational VRAM slot winner: refresh > video > sprite > CPU, with a starved CPU jumping sprite.
// Zero latency; no backpressure, losing requesters simply stay pending for a later slot.
module vdp18_vram_prio
  import vdp18_vram_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic [3:0] wait_i,
  input  logic [3:0] max_wait_i,
  output owner_t     owner_o
);

  logic cpu_starved;

  assign cpu_starved = req_i[REQ_CPU] && (wait_i >= max_wait_i);

  always_comb begin
    owner_o = NONE;
    if (req_i[REQ_REF]) begin
      owner_o = REF;
    end else if (req_i[REQ_VID]) begin
      owner_o = VID;
    end else if (cpu_starved) begin
      owner_o = CPU;
    end else if (req_i[REQ_SPR]) begin
      owner_o = SPR;
    end else if (req_i[REQ_CPU]) begin
      owner_o = CPU;
    end
  end

endmodule

// File: rtl/vdp18_vram_sched.sv
// VRAM slot scheduler: one access per two pixel enables, granted at slot start, ack + read data on the slot-end edge.
// Requesters hold their request until ack; optional refresh reads under VDP18_VRAM_REFRESH_EN.
module vdp18_vram_sched
  import vdp18_vram_pkg::*;
#(
  parameter int unsigned CPU_MAX_WAIT   = 8,
  parameter int unsigned REFRESH_PERIOD = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clk_en_5m37_i,
  input  logic               vid_req_i,
  input  logic [VRAM_AW-1:0] vid_a_i,
  output logic               vid_ack_o,
  input  logic               spr_req_i,
  input  logic [VRAM_AW-1:0] spr_a_i,
  output logic               spr_ack_o,
  input  logic               cpu_req_i,
  input  logic               cpu_we_i,
  input  logic [VRAM_AW-1:0] cpu_a_i,
  input  logic [VRAM_DW-1:0] cpu_d_i,
  output logic               cpu_ack_o,
  output logic [VRAM_DW-1:0] rd_data_o,
  output logic [VRAM_AW-1:0] vram_a_o,
  output logic [VRAM_DW-1:0] vram_d_o,
  output logic               vram_we_o,
  input  logic [VRAM_DW-1:0] vram_d_i
);

  localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

  state_t             state_q, state_d;
  owner_t             owner_q, owner_d, win;
  logic               phase_q, phase_d;
  logic [VRAM_AW-1:0] addr_q, addr_d;
  logic [VRAM_DW-1:0] wdat_q, wdat_d;
  logic [VRAM_DW-1:0] rd_data_q, rd_data_d;
  logic               we_q, we_d;
  logic               vid_ack_q, vid_ack_d;
  logic               spr_ack_q, spr_ack_d;
  logic               cpu_ack_q, cpu_ack_d;
  logic [3:0]         wait_q, wait_d;
  logic [3:0]         req_vec;
  logic               ref_pend;
  logic [VRAM_AW-1:0] ref_addr;
  logic               slot_start, slot_end, grant, done;

  assign slot_start = clk_en_5m37_i && !phase_q;
  assign slot_end   = clk_en_5m37_i && phase_q;
  assign phase_d    = phase_q ^ clk_en_5m37_i;
  assign req_vec    = {ref_pend, vid_req_i, spr_req_i, cpu_req_i};

  vdp18_vram_prio u_prio (
    .req_i      (req_vec),
    .wait_i     (wait_q),
    .max_wait_i (MAX_WAIT),
    .owner_o    (win)
  );

  // The FSM is always IDLE at a slot start, since ACCESS ends on every slot end.
  assign grant = (state_q == IDLE) && slot_start && (win != NONE);
  assign done  = (state_q == ACCESS) && slot_end;

`ifdef VDP18_VRAM_REFRESH_EN
  localparam int unsigned    RCW      = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [RCW-1:0] REF_LAST = RCW'(REFRESH_PERIOD - 1);
  localparam logic [RCW-1:0] REF_ONE  = RCW'(1);

  logic [RCW-1:0] ref_cnt_q, ref_cnt_d;
  logic           ref_pend_q, ref_pend_d;
  logic [6:0]     ref_row_q, ref_row_d;

  // A new refresh due at the same slot start as a grant takes precedence over the clear.
  always_comb begin
    ref_cnt_d  = ref_cnt_q;
    ref_pend_d = ref_pend_q;
    ref_row_d  = ref_row_q;
    if (grant && (win == REF)) begin
      ref_pend_d = 1'b0;
      ref_row_d  = ref_row_q + 7'd1;
    end
    if (slot_start) begin
      if (ref_cnt_q == REF_LAST) begin
        ref_cnt_d  = '0;
        ref_pend_d = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q + REF_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
      ref_row_q  <= '0;
    end else begin
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      ref_row_q  <= ref_row_d;
    end
  end

  assign ref_pend = ref_pend_q;
  assign ref_addr = {{(VRAM_AW-7){1'b0}}, ref_row_q};
`else
  assign ref_pend = 1'b0;
  assign ref_addr = '0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ACCESS;
      ACCESS:  if (slot_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    we_d      = we_q;
    rd_data_d = rd_data_q;
    vid_ack_d = 1'b0;
    spr_ack_d = 1'b0;
    cpu_ack_d = 1'b0;
    if (grant) begin
      owner_d = win;
      wdat_d  = cpu_d_i;
      we_d    = (win == CPU) && cpu_we_i;
      case (win)
        REF:     addr_d = ref_addr;
        VID:     addr_d = vid_a_i;
        SPR:     addr_d = spr_a_i;
        CPU:     addr_d = cpu_a_i;
        default: addr_d = addr_q;
      endcase
    end
    if (done) begin
      we_d = 1'b0;
      // Refresh is a dummy read: data and acks stay untouched.
      if ((owner_q != REF) && !we_q) begin
        rd_data_d = vram_d_i;
      end
      vid_ack_d = (owner_q == VID);
      spr_ack_d = (owner_q == SPR);
      cpu_ack_d = (owner_q == CPU);
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (grant && (win == CPU)) begin
      wait_d = '0;
    end else if (slot_start && cpu_req_i && (wait_q != 4'hF)) begin
      wait_d = wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      phase_q   <= 1'b0;
      owner_q   <= NONE;
      addr_q    <= '0;
      wdat_q    <= '0;
      we_q      <= 1'b0;
      rd_data_q <= '0;
      vid_ack_q <= 1'b0;
      spr_ack_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      phase_q   <= phase_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      we_q      <= we_d;
      rd_data_q <= rd_data_d;
      vid_ack_q <= vid_ack_d;
      spr_ack_q <= spr_ack_d;
      cpu_ack_q <= cpu_ack_d;
      wait_q    <= wait_d;
    end
  end

  assign vram_a_o  = addr_q;
  assign vram_d_o  = wdat_q;
  assign vram_we_o = we_q;
  assign rd_data_o = rd_data_q;
  assign vid_ack_o = vid_ack_q;
  assign spr_ack_o = spr_ack_q;
  assign cpu_ack_o = cpu_ack_q;

endmodule

// File: tb/tb_vdp18_vram_sched.sv
// Bench for vdp18_vram_sched: slot-level reference model plus directed scenarios with literal expectations.
module tb_vdp18_vram_sched;

  localparam int MAXW = 8;
  localparam int RP   = 4;

  localparam int O_NONE = 0;
  localparam int O_REF  = 1;
  localparam int O_VID  = 2;
  localparam int O_SPR  = 3;
  localparam int O_CPU  = 4;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        clk_en_5m37_i = 1'b0;
  logic        vid_req_i = 1'b0;
  logic [13:0] vid_a_i = '0;
  logic        vid_ack_o;
  logic        spr_req_i = 1'b0;
  logic [13:0] spr_a_i = '0;
  logic        spr_ack_o;
  logic        cpu_req_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [13:0] cpu_a_i = '0;
  logic [7:0]  cpu_d_i = '0;
  logic        cpu_ack_o;
  logic [7:0]  rd_data_o;
  logic [13:0] vram_a_o;
  logic [7:0]  vram_d_o;
  logic        vram_we_o;
  logic [7:0]  vram_d_i;

  always #5 clk = ~clk;

  // VRAM stand-in: read data is a fixed function of the address.
  assign vram_d_i = vram_a_o[7:0] ^ 8'h3C;

  vdp18_vram_sched #(
    .CPU_MAX_WAIT   (MAXW),
    .REFRESH_PERIOD (RP)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .clk_en_5m37_i (clk_en_5m37_i),
    .vid_req_i     (vid_req_i),
    .vid_a_i       (vid_a_i),
    .vid_ack_o     (vid_ack_o),
    .spr_req_i     (spr_req_i),
    .spr_a_i       (spr_a_i),
    .spr_ack_o     (spr_ack_o),
    .cpu_req_i     (cpu_req_i),
    .cpu_we_i      (cpu_we_i),
    .cpu_a_i       (cpu_a_i),
    .cpu_d_i       (cpu_d_i),
    .cpu_ack_o     (cpu_ack_o),
    .rd_data_o     (rd_data_o),
    .vram_a_o      (vram_a_o),
    .vram_d_o      (vram_d_o),
    .vram_we_o     (vram_we_o),
    .vram_d_i      (vram_d_i)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel enable every other clock; en_run=0 stalls it.
  bit en_run = 1'b1;
  bit tog = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (en_run) begin
        tog = !tog;
        clk_en_5m37_i = tog;
      end else begin
        clk_en_5m37_i = 1'b0;
      end
    end
  end

  function automatic int pick(bit rf, bit v, bit s, bit c, int wt);
    if (rf) return O_REF;
    if (v) return O_VID;
    if (c && wt >= MAXW) return O_CPU;
    if (s) return O_SPR;
    if (c) return O_CPU;
    return O_NONE;
  endfunction

  // Reference model state, in terms of slots and the access in flight.
  int          m_phase = 0, m_busy = 0, m_owner = 0, m_we = 0, m_wait = 0;
  int          m_slots = 0, m_ref_pend = 0, m_ref_row = 0;
  logic [13:0] m_addr = '0;
  logic [7:0]  m_d = '0, m_rd = '0;
  int          m_vack = 0, m_sack = 0, m_cack = 0;
  int          mw;
  bit          mdue;

  int          cyc = 0;
  int          n_vid = 0, n_spr = 0, n_cpu = 0;
  int          t_vid = 0, t_cpu = 0;
  int          we_cycles = 0;
  int          we_addr = 0;
  int          order[$];
  int          ref_log[$];
  bit          ref_watch = 1'b0;
  logic [13:0] prev_a = '0;

  always @(posedge clk) begin
    m_vack = 0;
    m_sack = 0;
    m_cack = 0;
    if (reset_i) begin
      m_phase = 0; m_busy = 0; m_owner = O_NONE; m_we = 0; m_wait = 0;
      m_slots = 0; m_ref_pend = 0; m_ref_row = 0;
      m_addr = '0; m_d = '0; m_rd = '0;
    end else if (clk_en_5m37_i) begin
      if (m_phase == 0) begin
        mdue = 1'b0;
`ifdef VDP18_VRAM_REFRESH_EN
        mdue = ((m_slots % RP) == RP - 1);
`endif
        m_slots++;
        mw = pick(m_ref_pend != 0, vid_req_i, spr_req_i, cpu_req_i, m_wait);
        if (mw != O_NONE) begin
          m_busy  = 1;
          m_owner = mw;
          m_we    = (mw == O_CPU && cpu_we_i) ? 1 : 0;
          m_d     = cpu_d_i;
          case (mw)
            O_REF:   m_addr = 14'(m_ref_row);
            O_VID:   m_addr = vid_a_i;
            O_SPR:   m_addr = spr_a_i;
            default: m_addr = cpu_a_i;
          endcase
          if (mw == O_REF) begin
            m_ref_pend = 0;
            m_ref_row  = (m_ref_row + 1) % 128;
          end
        end
        if (mw == O_CPU) m_wait = 0;
        else if (cpu_req_i && m_wait < 15) m_wait++;
        if (mdue) m_ref_pend = 1;
        m_phase = 1;
      end else begin
        if (m_busy != 0) begin
          if (m_owner != O_REF && m_we == 0) m_rd = m_addr[7:0] ^ 8'h3C;
          m_vack = (m_owner == O_VID) ? 1 : 0;
          m_sack = (m_owner == O_SPR) ? 1 : 0;
          m_cack = (m_owner == O_CPU) ? 1 : 0;
          m_busy = 0;
        end
        m_phase = 0;
      end
    end

    #2;
    cyc++;
    chk("vram_we", vram_we_o, (m_busy != 0 && m_we != 0) ? 1 : 0);
    chk("rd_data", rd_data_o, m_rd);
    chk("vid_ack", vid_ack_o, m_vack);
    chk("spr_ack", spr_ack_o, m_sack);
    chk("cpu_ack", cpu_ack_o, m_cack);
    if (m_busy != 0) begin
      chk("vram_a", vram_a_o, m_addr);
      if (m_we != 0) chk("vram_d", vram_d_o, m_d);
    end

    if (vid_ack_o) begin n_vid++; order.push_back(O_VID); t_vid = cyc; end
    if (spr_ack_o) begin n_spr++; order.push_back(O_SPR); end
    if (cpu_ack_o) begin n_cpu++; order.push_back(O_CPU); t_cpu = cyc; end
    if (vram_we_o) begin we_cycles++; we_addr = vram_a_o; end
    if (ref_watch && prev_a == 14'h3F00 && vram_a_o != 14'h3F00) ref_log.push_back(vram_a_o);
    prev_a = vram_a_o;
  end

  function automatic int ack_cnt(input int which);
    if (which == O_VID) return n_vid;
    if (which == O_SPR) return n_spr;
    return n_cpu;
  endfunction

  task automatic wait_ack(input int which, input int target, input int budget, input string name);
    int n = 0;
    while (ack_cnt(which) < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (ack_cnt(which) < target) begin
      checks++;
      failures++;
      $display("FAIL %s: ack count %0d after %0d cycles, required %0d", name, ack_cnt(which), budget, target);
    end
  endtask

  task automatic wait_addr(input logic [13:0] a, input int budget, input string name);
    int n = 0;
    while (vram_a_o !== a && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (vram_a_o !== a) begin
      checks++;
      failures++;
      $display("FAIL %s: vram_a_o=0x%0h, required 0x%0h within %0d cycles", name, vram_a_o, a, budget);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  int bv, bs, bc, ob, wb, s1, s2, rb;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_vram_a", vram_a_o, 0);
    chk("rst_vram_d", vram_d_o, 0);
    chk("rst_vram_we", vram_we_o, 0);
    chk("rst_rd_data", rd_data_o, 0);
    chk("rst_acks", {vid_ack_o, spr_ack_o, cpu_ack_o}, 0);
    reset_i = 1'b0;
    repeat (4) @(negedge clk);

    // Single CPU write.
    bc = n_cpu; wb = we_cycles;
    cpu_a_i = 14'h1234; cpu_d_i = 8'hA5; cpu_we_i = 1'b1; cpu_req_i = 1'b1;
    wait_ack(O_CPU, bc + 1, 40, "t2_cpu_ack");
    cpu_req_i = 1'b0; cpu_we_i = 1'b0;
    repeat (8) @(negedge clk);
    chk("t2_ack_count", n_cpu - bc, 1);
    chk("t2_we_cycles", we_cycles - wb, 2);
    chk("t2_we_addr", we_addr, 14'h1234);
    chk("t2_rd_unchanged", rd_data_o, 8'h00);

    // Video, sprite and CPU reads raised together.
    ob = order.size(); bv = n_vid; bs = n_spr; bc = n_cpu;
    vid_a_i = 14'h0111; spr_a_i = 14'h0222; cpu_a_i = 14'h0333; cpu_we_i = 1'b0;
    vid_req_i = 1'b1; spr_req_i = 1'b1; cpu_req_i = 1'b1;
    for (int i = 0; i < 80 && (vid_req_i || spr_req_i || cpu_req_i); i++) begin
      @(negedge clk);
      if (n_vid > bv) vid_req_i = 1'b0;
      if (n_spr > bs) spr_req_i = 1'b0;
      if (n_cpu > bc) cpu_req_i = 1'b0;
    end
    chk("t3_all_acked", {vid_req_i, spr_req_i, cpu_req_i}, 0);
    chk("t3_first_vid", (order.size() > ob) ? order[ob] : -1, O_VID);
    chk("t3_second_spr", (order.size() > ob + 1) ? order[ob + 1] : -1, O_SPR);
    chk("t3_third_cpu", (order.size() > ob + 2) ? order[ob + 2] : -1, O_CPU);
`ifndef VDP18_VRAM_REFRESH_EN
    chk("t3_consecutive_slots", t_cpu - t_vid, 8);
`endif
    chk("t3_rd_last", rd_data_o, 8'h0F);
    repeat (6) @(negedge clk);

    // Sprite held constantly while the CPU waits.
    bs = n_spr; bc = n_cpu;
    spr_a_i = 14'h0444; cpu_a_i = 14'h0555;
    spr_req_i = 1'b1; cpu_req_i = 1'b1;
    wait_ack(O_CPU, bc + 1, 100, "t4_cpu_first");
    s1 = n_spr - bs;
    wait_ack(O_CPU, bc + 2, 100, "t4_cpu_second");
    s2 = n_spr - bs - s1;
    spr_req_i = 1'b0; cpu_req_i = 1'b0;
`ifndef VDP18_VRAM_REFRESH_EN
    chk("t4_spr_before_cpu", s1, 8);
    chk("t4_spr_after_wait_clear", s2, 8);
`endif
    repeat (8) @(negedge clk);

    // Pixel enable stalled in the middle of a CPU read.
    bc = n_cpu;
    cpu_a_i = 14'h0055; cpu_we_i = 1'b0; cpu_req_i = 1'b1;
    wait_addr(14'h0055, 20, "t5_access_start");
    en_run = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_no_ack_stalled", n_cpu - bc, 0);
    chk("t5_addr_held", vram_a_o, 14'h0055);
    en_run = 1'b1;
    wait_ack(O_CPU, bc + 1, 20, "t5_ack_after_stall");
    cpu_req_i = 1'b0;
    chk("t5_rd", rd_data_o, 8'h69);
    repeat (8) @(negedge clk);

    // Reset in the middle of a video access.
    bv = n_vid;
    vid_a_i = 14'h2AAA; vid_req_i = 1'b1;
    wait_addr(14'h2AAA, 20, "t6_access_start");
    reset_i = 1'b1;
    #1;
    chk("t6_rst_vram_a", vram_a_o, 0);
    chk("t6_rst_vram_we", vram_we_o, 0);
    chk("t6_rst_rd_data", rd_data_o, 0);
    chk("t6_rst_acks", {vid_ack_o, spr_ack_o, cpu_ack_o}, 0);
    repeat (2) @(negedge clk);
    chk("t6_no_ack_in_reset", n_vid - bv, 0);
    reset_i = 1'b0;
    wait_ack(O_VID, bv + 1, 20, "t6_regrant");
    vid_req_i = 1'b0;
    chk("t6_rd", rd_data_o, 8'h96);
    repeat (6) @(negedge clk);

`ifdef VDP18_VRAM_REFRESH_EN
    // Video held from reset: every 4th slot is a refresh with row 0,1,2,...
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    rb = ref_log.size(); bv = n_vid;
    vid_a_i = 14'h3F00; vid_req_i = 1'b1;
    wait_ack(O_VID, bv + 1, 20, "t7_first_vid");
    ref_watch = 1'b1;
    repeat (80) @(negedge clk);
    ref_watch = 1'b0;
    vid_req_i = 1'b0;
    chk("t7_ref_count", (ref_log.size() - rb >= 4) ? 1 : 0, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t7_ref_addr%0d", i), (ref_log.size() > rb + i) ? ref_log[rb + i] : -1, i);
    end
    repeat (6) @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
